regfile_writeback: RTL and testbench

Write-side front end of the integer register file. Arbitrates result traffic from N_SRC execution units (ALU, LSU, MUL/DIV) into the register file's single write port through a registered stage. It also maintains a per-register pending-write scoreboard that the decode stage queries to stall on RAW hazards. It sits between the execution units and the register file's `we`/`wa`/`wd` inputs.

---
 rtl/regfile_writeback_if.sv | 34 +++
 rtl/regfile_writeback.sv | 116 +++++++++++
 tb/tb_regfile_writeback.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_if.sv
// Result-bus, issue and register-file write signals between the execution
// units / decode and the writeback front end.
interface regfile_writeback_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int N_SRC      = 3
);
  logic                               clk_en;
  logic                               flush;
  logic [N_SRC-1:0]                   src_valid;
  logic [N_SRC-1:0]                   src_ready;
  logic [N_SRC-1:0][REG_ADDR_W-1:0]   src_rd;
  logic [N_SRC-1:0][XLEN-1:0]         src_data;
  logic                               issue_valid;
  logic [REG_ADDR_W-1:0]              issue_rd;
  logic                               issue_stall;
  logic [REG_ADDR_W-1:0]              qa1;
  logic [REG_ADDR_W-1:0]              qa2;
  logic                               busy1;
  logic                               busy2;
  logic                               we;
  logic [REG_ADDR_W-1:0]              wa;
  logic [XLEN-1:0]                    wd;

  modport master (
    output clk_en, flush, src_valid, src_rd, src_data, issue_valid, issue_rd, qa1, qa2,
    input  src_ready, issue_stall, busy1, busy2, we, wa, wd
  );

  modport slave (
    input  clk_en, flush, src_valid, src_rd, src_data, issue_valid, issue_rd, qa1, qa2,
    output src_ready, issue_stall, busy1, busy2, we, wa, wd
  );
endinterface

// File: rtl/regfile_writeback.sv
// Round-robin arbiter from the execution units into the register file's single
// write port, plus a per-register pending-write counter for RAW stalls.

// Saturating 2-bit pending-write counter for one architectural register.
module regfile_wb_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en_i,
  input  logic       flush_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [1:0] cnt_o
);
  logic [1:0] cnt_q, cnt_d;

  // Simultaneous inc/dec cancel; neither end wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i)                                cnt_d = 2'd0;
    else if (inc_i && !dec_i && cnt_q != 2'd3)  cnt_d = cnt_q + 2'd1;
    else if (dec_i && !inc_i && cnt_q != 2'd0)  cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt_q <= 2'd0;
    else if (clk_en_i) cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

module regfile_writeback #(
  parameter int XLEN       = 32,
  parameter int REG_COUNT  = 32,
  parameter int REG_ADDR_W = 5,
  parameter int N_SRC      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_writeback_if.slave wb
);
  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [PTR_W-1:0]          ptr_q, ptr_d, gidx;
  logic [N_SRC-1:0]          grant;
  logic                      found, gate, xfer;
  int                        idx;
  logic                      we_q;
  logic [REG_ADDR_W-1:0]     wa_q;
  logic [XLEN-1:0]           wd_q;
  logic [REG_COUNT-1:0][1:0] cnt;

  assign gate = wb.clk_en & ~wb.flush & rst_n;

  // First valid source at or after ptr_q, wrapping.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!found && wb.src_valid[idx]) begin
        found = 1'b1;
        gidx  = PTR_W'(idx);
      end
    end
    if (found && gate) grant[gidx] = 1'b1;
  end

  assign xfer         = |grant;
  assign ptr_d        = (gidx == PTR_W'(N_SRC - 1)) ? '0 : gidx + PTR_W'(1);
  assign wb.src_ready = grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
      ptr_q <= '0;
    end else if (wb.clk_en) begin
      if (xfer) begin
        we_q  <= (wb.src_rd[gidx] != '0);
        wa_q  <= wb.src_rd[gidx];
        wd_q  <= wb.src_data[gidx];
        ptr_q <= ptr_d;
      end else begin
        we_q  <= 1'b0;
      end
    end
  end

  assign wb.we = we_q;
  assign wb.wa = wa_q;
  assign wb.wd = wd_q;

  // x0 has no counter: it is never pending.
  assign cnt[0] = 2'd0;

  for (genvar r = 1; r < REG_COUNT; r++) begin : g_cnt
    regfile_wb_cnt u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clk_en_i (wb.clk_en),
      .flush_i  (wb.flush),
      .inc_i    (wb.issue_valid & ~wb.issue_stall & (wb.issue_rd == REG_ADDR_W'(r))),
      .dec_i    (we_q & (wa_q == REG_ADDR_W'(r))),
      .cnt_o    (cnt[r])
    );
  end

  assign wb.issue_stall = (cnt[wb.issue_rd] == 2'd3) & (wb.issue_rd != '0);
  assign wb.busy1       = (cnt[wb.qa1] != 2'd0);
  assign wb.busy2       = (cnt[wb.qa2] != 2'd0);
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench: stimulus pushes expected register-file writes into a queue,
// a negedge monitor pops and compares every committed write.
module tb_regfile_writeback;
  localparam int XLEN = 32;
  localparam int RC   = 32;
  localparam int AW   = 5;
  localparam int NS   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_writeback_if #(.XLEN(XLEN), .REG_ADDR_W(AW), .N_SRC(NS)) wb ();

  regfile_writeback #(.XLEN(XLEN), .REG_COUNT(RC), .REG_ADDR_W(AW), .N_SRC(NS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb.slave)
  );

  typedef struct packed {
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_t w;
    w.wa = a;
    w.wd = d;
    exp_q.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    wb.src_rd[i]   = rd;
    wb.src_data[i] = d;
  endtask

  // A committed write is one held in the output stage while the file is enabled.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && wb.clk_en && wb.we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got write wa=%0d wd=%h, expected none", wb.wa, wb.wd);
      end else begin
        e = exp_q.pop_front();
        chk("wb_addr", 64'(wb.wa), 64'(e.wa));
        chk("wb_data", 64'(wb.wd), 64'(e.wd));
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && wb.clk_en && !wb.flush && wb.we && wb.wa != '0)
      assert (dut.cnt[wb.wa] != 2'd0) else $error("scoreboard underflow on x%0d", wb.wa);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1, "watchdog");
  end

  logic [2:0]      rr_gnt  [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  int              rr_src  [6] = '{0, 1, 2, 0, 1, 2};
  logic [AW-1:0]   rr_rd   [6] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
  logic [XLEN-1:0] rr_data [6] = '{32'h0A0A_0010, 32'h1B1B_0011, 32'h2C2C_0012,
                                   32'h3D3D_0013, 32'h4E4E_0014, 32'h5F5F_0015};

  initial begin
    wb.clk_en = 1'b1;  wb.flush = 1'b0;
    wb.src_valid = 3'b111; wb.src_rd = '0; wb.src_data = '0;
    wb.issue_valid = 1'b0; wb.issue_rd = '0;
    wb.qa1 = 5'd5; wb.qa2 = 5'd9;

    // Reset
    repeat (2) @(posedge clk);
    mid();
    chk("rst_ready", 64'(wb.src_ready), 64'h0);
    chk("rst_we",    64'(wb.we),        64'h0);
    chk("rst_wa",    64'(wb.wa),        64'h0);
    chk("rst_wd",    64'(wb.wd),        64'h0);
    chk("rst_busy1", 64'(wb.busy1),     64'h0);
    chk("rst_busy2", 64'(wb.busy2),     64'h0);
    chk("rst_stall", 64'(wb.issue_stall), 64'h0);
    tick();
    wb.src_valid = '0;
    rst_n = 1'b1;

    // Round robin from ptr = 0; destinations issued first
    for (int i = 0; i < 6; i++) begin
      wb.issue_valid = 1'b1;
      wb.issue_rd    = rr_rd[i];
      tick();
    end
    wb.issue_valid = 1'b0;
    for (int i = 0; i < 3; i++) set_src(i, rr_rd[i], rr_data[i]);
    wb.src_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      push(rr_rd[i], rr_data[i]);
      mid();
      chk("rr_grant", 64'(wb.src_ready), 64'(rr_gnt[i]));
      if (i > 0) chk("rr_we_each_cycle", 64'(wb.we), 64'h1);
      tick();
      if (i < 3) set_src(rr_src[i], rr_rd[i+3], rr_data[i+3]);
      else       wb.src_valid[rr_src[i]] = 1'b0;
    end
    mid();
    chk("rr_we_last", 64'(wb.we), 64'h1);
    tick();
    tick();

    // Single ALU result to x5
    wb.issue_valid = 1'b1; wb.issue_rd = 5'd5;
    mid();
    chk("a_busy_pre", 64'(wb.busy1), 64'h0);
    tick();
    wb.issue_valid = 1'b0;
    set_src(0, 5'd5, 32'hDEAD_BEEF);
    wb.src_valid = 3'b001;
    push(5'd5, 32'hDEAD_BEEF);
    mid();
    chk("a_ready", 64'(wb.src_ready), 64'h1);
    chk("a_busy_issued", 64'(wb.busy1), 64'h1);
    tick();
    wb.src_valid = '0;
    mid();
    chk("a_we", 64'(wb.we), 64'h1);
    chk("a_busy_commit", 64'(wb.busy1), 64'h1);
    tick();
    mid();
    chk("a_busy_clear", 64'(wb.busy1), 64'h0);
    tick();

    // Issue x7, write it three cycles later
    wb.qa1 = 5'd7;
    wb.issue_valid = 1'b1; wb.issue_rd = 5'd7;
    mid();
    chk("c_busy_pre", 64'(wb.busy1), 64'h0);
    tick();
    wb.issue_valid = 1'b0;
    mid(); chk("c_busy_n1", 64'(wb.busy1), 64'h1); tick();
    mid(); chk("c_busy_n2", 64'(wb.busy1), 64'h1); tick();
    set_src(0, 5'd7, 32'h7777_0007);
    wb.src_valid = 3'b001;
    push(5'd7, 32'h7777_0007);
    mid();
    chk("c_ready", 64'(wb.src_ready), 64'h1);
    chk("c_busy_n3", 64'(wb.busy1), 64'h1);
    tick();
    wb.src_valid = '0;
    mid();
    chk("c_busy_xfer1", 64'(wb.busy1), 64'h1);
    tick();
    mid();
    chk("c_busy_xfer2", 64'(wb.busy1), 64'h0);
    tick();

    // x9 saturates at 3; inc and dec on one edge cancel
    wb.issue_valid = 1'b1; wb.issue_rd = 5'd9;
    mid(); chk("d_stall_c0", 64'(wb.issue_stall), 64'h0); tick();
    mid(); chk("d_stall_c1", 64'(wb.issue_stall), 64'h0);
           chk("d_busy2",    64'(wb.busy2),       64'h1); tick();
    mid(); chk("d_stall_c2", 64'(wb.issue_stall), 64'h0); tick();
    mid(); chk("d_stall_c3", 64'(wb.issue_stall), 64'h1); tick();
    wb.issue_valid = 1'b0;
    set_src(0, 5'd9, 32'h9999_0001);
    wb.src_valid = 3'b001;
    push(5'd9, 32'h9999_0001);
    mid(); chk("d_stall_held", 64'(wb.issue_stall), 64'h1); tick();
    wb.src_valid = '0;
    mid(); chk("d_stall_commit", 64'(wb.issue_stall), 64'h1); tick();
    set_src(0, 5'd9, 32'h9999_0002);
    wb.src_valid = 3'b001;
    push(5'd9, 32'h9999_0002);
    mid(); chk("d_stall_dec", 64'(wb.issue_stall), 64'h0); tick();
    wb.src_valid = '0;
    wb.issue_valid = 1'b1;
    mid(); chk("d_stall_simul", 64'(wb.issue_stall), 64'h0); tick();
    mid(); chk("d_stall_after_simul", 64'(wb.issue_stall), 64'h0); tick();
    wb.issue_valid = 1'b0;
    mid(); chk("d_stall_resat", 64'(wb.issue_stall), 64'h1); tick();

    // Writes and issues to x0
    set_src(0, 5'd0, 32'h0BAD_0000);
    wb.src_valid = 3'b001;
    mid(); chk("e_ready_x0", 64'(wb.src_ready), 64'h1); tick();
    wb.src_valid = '0;
    wb.qa1 = 5'd0;
    wb.issue_valid = 1'b1; wb.issue_rd = 5'd0;
    mid(); chk("e_we_x0", 64'(wb.we), 64'h0); tick();
    wb.issue_valid = 1'b0;
    mid();
    chk("e_busy_x0",  64'(wb.busy1),       64'h0);
    chk("e_stall_x0", 64'(wb.issue_stall), 64'h0);
    tick();

    // Stall gate, then flush
    wb.qa1 = 5'd3;
    wb.issue_valid = 1'b1; wb.issue_rd = 5'd3;  tick();
    tick();
    wb.issue_rd = 5'd20;                         tick();
    wb.issue_valid = 1'b0;
    set_src(1, 5'd20, 32'hC0DE_0020);
    wb.src_valid = 3'b010;
    push(5'd20, 32'hC0DE_0020);
    mid(); chk("f_ready", 64'(wb.src_ready), 64'h2); tick();
    wb.clk_en = 1'b0;
    wb.src_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("f_gated_ready", 64'(wb.src_ready), 64'h0);
      chk("f_gated_we",    64'(wb.we),        64'h1);
      chk("f_gated_wa",    64'(wb.wa),        64'd20);
      chk("f_gated_wd",    64'(wb.wd),        64'hC0DE_0020);
      chk("f_gated_busy",  64'(wb.busy1),     64'h1);
      tick();
    end
    wb.clk_en = 1'b1;
    wb.flush  = 1'b1;
    mid(); chk("f_flush_ready", 64'(wb.src_ready), 64'h0); tick();
    wb.flush = 1'b0;
    wb.src_valid = '0;
    mid();
    chk("f_busy_r3",  64'(wb.busy1), 64'h0);
    chk("f_busy_r9",  64'(wb.busy2), 64'h0);
    chk("f_we",       64'(wb.we),    64'h0);
    tick();
    tick();

    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
